// File: rtl/pkt_pkg.sv
// Shared types and constants for the packetizer run controller.
package pkt_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_ARM       = 3'd2,
        S_WAIT_SYNC = 3'd3,
        S_RUNNING   = 3'd4,
        S_FLUSH     = 3'd5,
        S_DONE      = 3'd6,
        S_ERROR     = 3'd7
    } seq_state_t;

    // One header word plus 1024 data words, eof on the last.
    localparam int PKT_WORDS_DFLT = 1025;

    localparam int ERR_OVF = 0;
    localparam int ERR_LEN = 1;
    localparam int ERR_TMO = 2;

    function automatic logic seq_active(input seq_state_t s);
        return (s == S_WAIT_SYNC) || (s == S_RUNNING) || (s == S_FLUSH);
    endfunction

endpackage

// File: rtl/edge_counter.sv
// Rising-edge detector feeding a saturating event counter with synchronous clear.
module edge_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             sig,
    output logic             rise,
    output logic [CNT_W-1:0] count
);

    logic sig_prev;

    // The history tracks sig every cycle so a level held across enable changes is not an edge.
    assign rise = sig && !sig_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_prev <= 1'b0;
            count    <= '0;
        end else begin
            sig_prev <= sig;
            if (clr)
                count <= '0;
            else if (en && rise && (count != '1))
                count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/packet_sequencer.sv
// Run controller for the packetizer-to-10GbE path: arms the packetizer, counts and
// length-checks packets, stops on a packet boundary and tracks core overflows.
module packet_sequencer
    import pkt_pkg::*;
#(
    parameter int PKT_WORDS    = PKT_WORDS_DFLT,
    parameter int CNT_W        = 32,
    parameter int SYNC_TIMEOUT = 2**24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] num_packets,
    input  logic             sync_in,
    input  logic             tx_valid,
    input  logic             tx_eof,
    input  logic             tx_overflow,
    output logic             pkt_arm,
    output logic             pkt_rst,
    output logic             running,
    output logic             done,
    output logic [2:0]       err,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int WC_W  = $clog2(PKT_WORDS) + 1;
    localparam int TMR_W = $clog2(SYNC_TIMEOUT + 1);

    seq_state_t       state, state_nxt;
    logic [WC_W-1:0]  word_cnt, word_inc;
    logic [TMR_W-1:0] sync_tmr;
    logic [CNT_W-1:0] pkt_count_inc;
    logic             in_run, in_mon, clr;
    logic             eof_rise, eof_hit, ovf_rise, ovf_hit;
    logic             word_en, len_bad, tmr_done, pkt_limit;
    logic             sync_unused;

    // Sync is seen indirectly: the packetizer only raises tx_valid after it.
    assign sync_unused = sync_in;

    assign in_run  = (state == S_RUNNING) || (state == S_FLUSH);
    assign in_mon  = in_run || (state == S_WAIT_SYNC);
    assign clr     = (state == S_CLEAR);
    assign eof_hit = tx_valid && eof_rise && in_run;
    assign ovf_hit = ovf_rise && in_run;

    // A repeated eof word is not part of any packet, so it is not counted as a word either.
    assign word_en  = tx_valid && in_mon && !(tx_eof && !eof_rise);
    assign word_inc = (word_cnt == '1) ? word_cnt : word_cnt + 1'b1;
    assign len_bad  = eof_hit ? (word_inc != WC_W'(PKT_WORDS))
                              : (word_en && (word_cnt >= WC_W'(PKT_WORDS)));

    assign tmr_done      = (sync_tmr == TMR_W'(SYNC_TIMEOUT - 1));
    assign pkt_count_inc = (pkt_count == '1) ? pkt_count : pkt_count + 1'b1;
    assign pkt_limit     = eof_hit && (num_packets != '0) && (pkt_count_inc == num_packets);

    edge_counter #(.CNT_W(CNT_W)) u_eof_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (tx_valid && in_run),
        .sig   (tx_eof),
        .rise  (eof_rise),
        .count (pkt_count)
    );

    edge_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (in_run),
        .sig   (tx_overflow),
        .rise  (ovf_rise),
        .count (ovf_count)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_CLEAR;
            S_CLEAR:     state_nxt = stop ? S_IDLE : S_ARM;
            S_ARM: begin
                if (stop)    state_nxt = S_IDLE;
                else if (ce) state_nxt = S_WAIT_SYNC;
            end
            S_WAIT_SYNC: begin
                if (stop)          state_nxt = S_IDLE;
                else if (tx_valid) state_nxt = S_RUNNING;
                else if (tmr_done) state_nxt = S_ERROR;
            end
            S_RUNNING: begin
                // A packet closing on the stop cycle is counted and ends the run at once.
                if (eof_hit && (stop || pkt_limit))
                    state_nxt = S_DONE;
                else if (stop && !eof_hit)
                    state_nxt = ((word_cnt == '0) && !word_en) ? S_DONE : S_FLUSH;
            end
            S_FLUSH:     if (eof_hit) state_nxt = S_DONE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pkt_rst  <= 1'b1;
            pkt_arm  <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b0;
            err      <= '0;
            word_cnt <= '0;
            sync_tmr <= '0;
        end else begin
            state    <= state_nxt;
            pkt_rst  <= (state_nxt == S_IDLE) || (state_nxt == S_CLEAR) ||
                        (state_nxt == S_DONE) || (state_nxt == S_ERROR);
            pkt_arm  <= (state_nxt == S_ARM);
            running  <= seq_active(state_nxt);
            done     <= (state_nxt == S_DONE);
            sync_tmr <= (state == S_WAIT_SYNC) ? sync_tmr + 1'b1 : '0;

            if (clr || eof_hit)
                word_cnt <= '0;
            else if (word_en)
                word_cnt <= word_inc;

            if (clr) begin
                err <= '0;
            end else begin
                if ((state == S_WAIT_SYNC) && (state_nxt == S_ERROR)) err[ERR_TMO] <= 1'b1;
                if (len_bad) err[ERR_LEN] <= 1'b1;
                if (ovf_hit) err[ERR_OVF] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_packet_sequencer.sv
// Randomized bench for packet_sequencer; expectations come from per-run packet lists.
module tb_packet_sequencer;

    localparam int PW  = 1025;
    localparam int CW  = 32;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0, start = 1'b0, stop = 1'b0, sync_in = 1'b0;
    logic          tx_valid = 1'b0, tx_eof = 1'b0, tx_overflow = 1'b0;
    logic [CW-1:0] num_packets = '0;
    logic          pkt_arm, pkt_rst, running, done;
    logic [2:0]    err;
    logic [CW-1:0] pkt_count, ovf_count;

    int n_chk  = 0;
    int n_fail = 0;
    int ovf_left = 0;
    int ovf_w[3] = '{0, 0, 0};
    int ovf_l[3] = '{0, 0, 0};

    packet_sequencer #(.PKT_WORDS(PW), .CNT_W(CW), .SYNC_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .stop(stop),
        .num_packets(num_packets), .sync_in(sync_in), .tx_valid(tx_valid),
        .tx_eof(tx_eof), .tx_overflow(tx_overflow), .pkt_arm(pkt_arm),
        .pkt_rst(pkt_rst), .running(running), .done(done), .err(err),
        .pkt_count(pkt_count), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        tx_overflow = (ovf_left > 0);
        if (ovf_left > 0) ovf_left--;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int num, input int d);
        int arm_n = 0;
        num_packets = num;
        ce = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < d + 10 && !running; i++) begin
            ce = (i > d);
            cyc();
            if (pkt_arm) arm_n++;
        end
        ce = 1'b1;
        check_eq("arm_cycles", arm_n, d + 1);
        check_eq("run_started", running, 1);
        check_eq("cleared_pkt_count", pkt_count, 0);
        check_eq("cleared_err", err, 0);
        check_eq("cleared_ovf_count", ovf_count, 0);
    endtask

    task automatic begin_stream(input int delay);
        sync_in = 1'b1;
        cyc();
        sync_in = 1'b0;
        repeat (delay) cyc();
    endtask

    task automatic send_packet(input int len, input int stop_at, input bit dup);
        for (int w = 1; w <= len; w++) begin
            if (w > 1 && $urandom_range(0, 7) == 0) begin
                tx_valid = 1'b0;
                tx_eof   = 1'b0;
                cyc();
            end
            for (int k = 0; k < 3; k++)
                if (ovf_w[k] == w) ovf_left = ovf_l[k];
            tx_valid = 1'b1;
            tx_eof   = (w == len);
            stop     = (w == stop_at);
            cyc();
            stop = 1'b0;
            if (w == stop_at && w < len) begin
                check_eq("flush_running", running, 1);
                check_eq("flush_not_done", done, 0);
            end
        end
        if (dup) begin
            tx_valid = 1'b1;
            tx_eof   = 1'b1;
            cyc();
        end
        tx_valid = 1'b0;
        tx_eof   = 1'b0;
    endtask

    // Either a counted run or an unlimited run stopped inside its last packet.
    task automatic random_run();
        int         n, stop_at;
        int         lens[3];
        bit         use_stop;
        logic [2:0] e_err = '0;
        n = $urandom_range(1, 3);
        for (int i = 0; i < 3; i++)
            lens[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1000, 1040) : PW;
        use_stop = 1'($urandom_range(0, 1));
        start_run(use_stop ? 0 : n, $urandom_range(0, 3));
        begin_stream($urandom_range(0, 40));
        for (int i = 0; i < n; i++) begin
            stop_at = (use_stop && i == n - 1) ? $urandom_range(1, lens[i]) : 0;
            send_packet(lens[i], stop_at, 1'b0);
            if (lens[i] != PW) e_err[1] = 1'b1;
            check_eq("rnd_pkt_count", pkt_count, i + 1);
            check_eq("rnd_err", err, e_err);
            check_eq("rnd_running", running, (i < n - 1) ? 1 : 0);
        end
        check_eq("rnd_done", done, 1);
        check_eq("rnd_pkt_rst", pkt_rst, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_pkt_rst"}, pkt_rst, 1);
        check_eq({tag, "_pkt_arm"}, pkt_arm, 0);
        check_eq({tag, "_running"}, running, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_pkt_count"}, pkt_count, 0);
        check_eq({tag, "_ovf_count"}, ovf_count, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
        check_eq("idle_stop_ignored", running, 0);
        check_eq("idle_pkt_rst", pkt_rst, 1);

        // Three clean packets against a limit of three.
        start_run(3, 0);
        begin_stream(5);
        for (int i = 0; i < 3; i++) begin
            send_packet(PW, 0, 1'b0);
            check_eq("a_pkt_count", pkt_count, i + 1);
        end
        check_eq("a_done", done, 1);
        check_eq("a_pkt_rst", pkt_rst, 1);
        check_eq("a_err", err, 0);
        check_eq("a_running", running, 0);

        // Unlimited run, stop at word 500 of packet 2.
        start_run(0, 2);
        begin_stream(3);
        send_packet(PW, 0, 1'b0);
        send_packet(PW, 500, 1'b0);
        check_eq("b_done", done, 1);
        check_eq("b_pkt_count", pkt_count, 2);
        check_eq("b_err", err, 0);

        // No traffic: timeout after 100 cycles in WAIT_SYNC.
        start_run(1, 0);
        repeat (TMO - 1) cyc();
        check_eq("tmo_still_waiting", running, 1);
        check_eq("tmo_err_early", err, 0);
        cyc();
        check_eq("tmo_err", err, 3'b100);
        check_eq("tmo_running", running, 0);
        check_eq("tmo_done", done, 0);
        check_eq("tmo_pkt_rst", pkt_rst, 1);

        // Short packet flags a length error but the run continues.
        start_run(2, 1);
        begin_stream(3);
        send_packet(1000, 0, 1'b0);
        check_eq("len_pkt_count", pkt_count, 1);
        check_eq("len_err", err, 3'b010);
        check_eq("len_running", running, 1);
        send_packet(PW, 0, 1'b0);
        check_eq("len_pkt_count2", pkt_count, 2);
        check_eq("len_err2", err, 3'b010);
        check_eq("len_done", done, 1);

        // Three overflow pulses, one held for five cycles.
        ovf_w = '{100, 300, 600};
        ovf_l = '{1, 5, 2};
        start_run(1, 0);
        begin_stream(2);
        send_packet(PW, 0, 1'b0);
        check_eq("ovf_count", ovf_count, 3);
        check_eq("ovf_err", err, 3'b001);
        check_eq("ovf_pkt_count", pkt_count, 1);
        check_eq("ovf_done", done, 1);
        ovf_w = '{0, 0, 0};

        // Repeated eof cycle must be counted once.
        start_run(2, 0);
        begin_stream(1);
        send_packet(PW, 0, 1'b1);
        check_eq("dup_pkt_count", pkt_count, 1);
        check_eq("dup_running", running, 1);
        check_eq("dup_err", err, 0);
        send_packet(PW, 0, 1'b0);
        check_eq("dup_pkt_count2", pkt_count, 2);
        check_eq("dup_err2", err, 0);
        check_eq("dup_done", done, 1);

        // Asynchronous reset in the middle of packet 2.
        ovf_w = '{50, 0, 0};
        start_run(0, 0);
        begin_stream(2);
        send_packet(PW, 0, 1'b0);
        ovf_w = '{0, 0, 0};
        tx_valid = 1'b1;
        repeat (300) cyc();
        check_eq("pre_rst_pkt_count", pkt_count, 1);
        check_eq("pre_rst_ovf_count", ovf_count, 1);
        check_eq("pre_rst_running", running, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        start_run(1, 0);
        begin_stream(4);
        send_packet(PW, 0, 1'b0);
        check_eq("post_rst_pkt_count", pkt_count, 1);
        check_eq("post_rst_done", done, 1);
        check_eq("post_rst_err", err, 0);

        repeat (3) random_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
